// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: FSM states, load type codes, zero register.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    DRAIN     = 2'd2
  } wb_state_e;

  localparam logic [2:0] LOAD_B  = 3'd0;
  localparam logic [2:0] LOAD_H  = 3'd1;
  localparam logic [2:0] LOAD_W  = 3'd2;
  localparam logic [2:0] LOAD_BU = 3'd4;
  localparam logic [2:0] LOAD_HU = 3'd5;

  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/writeback_stage_load_align.sv
// load_align: picks the byte/half lane of a load word (big-endian lanes) and extends it.
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        load_type,
  input  logic [1:0]        byte_addr,
  input  logic [DATA_W-1:0] rsp_data,
  output logic [DATA_W-1:0] aligned_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Lane 0 is the most significant byte; halves round the address down.
    byte_sel = rsp_data[DATA_W - 8 - 8 * int'(byte_addr) +: 8];
    half_sel = byte_addr[1] ? rsp_data[15:0] : rsp_data[31:16];
    case (load_type)
      LOAD_B:  aligned_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LOAD_BU: aligned_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LOAD_H:  aligned_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LOAD_HU: aligned_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: aligned_data = rsp_data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// WB pipe stage: commits ALU results and load responses to the register file, one write per cycle.
// Optional WB_SUBWORD_LOAD_EN enables byte/half load selection and extension.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned RETIRE_W   = 32
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  memValid,
  output logic                  memReady,
  input  logic                  memRegWrite,
  input  logic                  memIsLoad,
  input  logic [REG_ADDR_W-1:0] memDestReg,
  input  logic [DATA_W-1:0]     memAluResult,
  input  logic [2:0]            memLoadType,
  input  logic                  flush,
  input  logic                  loadRspValid,
  input  logic [DATA_W-1:0]     loadRspData,
  output logic                  regWriteSignal,
  output logic [REG_ADDR_W-1:0] writeRegNumber,
  output logic [DATA_W-1:0]     writeData,
  output logic                  wbStall,
  output logic                  fwdValid,
  output logic [REG_ADDR_W-1:0] fwdRegNumber,
  output logic [DATA_W-1:0]     fwdData,
  output logic [RETIRE_W-1:0]   retireCount,
  output logic                  loadRspErr
);

  wb_state_e             state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [RETIRE_W-1:0]   retire_q, retire_d;
  logic                  err_q, err_d;
  logic [REG_ADDR_W-1:0] ld_dest_q, ld_dest_d;
  logic                  ld_we_q, ld_we_d;
  logic [DATA_W-1:0]     load_data;

`ifdef WB_SUBWORD_LOAD_EN
  logic [2:0] ld_type_q, ld_type_d;
  logic [1:0] ld_addr_q, ld_addr_d;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .load_type   (ld_type_q),
    .byte_addr   (ld_addr_q),
    .rsp_data    (loadRspData),
    .aligned_data(load_data)
  );
`else
  logic unused_load_type;
  assign unused_load_type = ^memLoadType;
  assign load_data        = loadRspData;
`endif

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    retire_d  = retire_q;
    err_d     = err_q;
    ld_dest_d = ld_dest_q;
    ld_we_d   = ld_we_q;
`ifdef WB_SUBWORD_LOAD_EN
    ld_type_d = ld_type_q;
    ld_addr_d = ld_addr_q;
`endif
    case (state_q)
      IDLE: begin
        if (loadRspValid) err_d = 1'b1;
        if (memValid) begin
          if (memIsLoad) begin
            ld_dest_d = memDestReg;
            ld_we_d   = memRegWrite;
`ifdef WB_SUBWORD_LOAD_EN
            ld_type_d = memLoadType;
            ld_addr_d = memAluResult[1:0];
`endif
            state_d   = WAIT_LOAD;
          end else begin
            retire_d = retire_q + RETIRE_W'(1);
            if (memRegWrite && memDestReg != REG_ADDR_W'(ZERO_REG)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = memDestReg;
              wr_data_d = memAluResult;
            end
          end
        end
      end
      WAIT_LOAD: begin
        // Flush beats a same-cycle response; only a flush with no response needs DRAIN.
        if (flush) begin
          state_d = loadRspValid ? IDLE : DRAIN;
        end else if (loadRspValid) begin
          retire_d = retire_q + RETIRE_W'(1);
          if (ld_we_q && ld_dest_q != REG_ADDR_W'(ZERO_REG)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ld_dest_q;
            wr_data_d = load_data;
          end
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (loadRspValid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      retire_q  <= '0;
      err_q     <= 1'b0;
      ld_dest_q <= '0;
      ld_we_q   <= 1'b0;
`ifdef WB_SUBWORD_LOAD_EN
      ld_type_q <= '0;
      ld_addr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      retire_q  <= retire_d;
      err_q     <= err_d;
      ld_dest_q <= ld_dest_d;
      ld_we_q   <= ld_we_d;
`ifdef WB_SUBWORD_LOAD_EN
      ld_type_q <= ld_type_d;
      ld_addr_q <= ld_addr_d;
`endif
    end
  end

  assign memReady       = rstN && (state_q == IDLE);
  assign wbStall        = (state_q != IDLE);
  assign regWriteSignal = wr_en_q;
  assign writeRegNumber = wr_addr_q;
  assign writeData      = wr_data_q;
  assign fwdValid       = wr_en_q;
  assign fwdRegNumber   = wr_addr_q;
  assign fwdData        = wr_data_q;
  assign retireCount    = retire_q;
  assign loadRspErr     = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; subword cases follow WB_SUBWORD_LOAD_EN.
module tb_writeback_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic        memValid, memReady, memRegWrite, memIsLoad;
  logic [4:0]  memDestReg;
  logic [31:0] memAluResult;
  logic [2:0]  memLoadType;
  logic        flush, loadRspValid;
  logic [31:0] loadRspData;
  logic        regWriteSignal, wbStall, fwdValid, loadRspErr;
  logic [4:0]  writeRegNumber, fwdRegNumber;
  logic [31:0] writeData, fwdData, retireCount;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned exp_retire = 0;

  writeback_stage #(.DATA_W(32), .REG_ADDR_W(5), .RETIRE_W(32)) dut (
    .clk           (clk),
    .rstN          (rstN),
    .memValid      (memValid),
    .memReady      (memReady),
    .memRegWrite   (memRegWrite),
    .memIsLoad     (memIsLoad),
    .memDestReg    (memDestReg),
    .memAluResult  (memAluResult),
    .memLoadType   (memLoadType),
    .flush         (flush),
    .loadRspValid  (loadRspValid),
    .loadRspData   (loadRspData),
    .regWriteSignal(regWriteSignal),
    .writeRegNumber(writeRegNumber),
    .writeData     (writeData),
    .wbStall       (wbStall),
    .fwdValid      (fwdValid),
    .fwdRegNumber  (fwdRegNumber),
    .fwdData       (fwdData),
    .retireCount   (retireCount),
    .loadRspErr    (loadRspErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_alu(input logic [4:0] dest, input logic [31:0] data);
    memValid = 1'b1; memRegWrite = 1'b1; memIsLoad = 1'b0;
    memDestReg = dest; memAluResult = data;
  endtask

  task automatic issue_load(input logic [4:0] dest, input logic [31:0] addr, input logic [2:0] ty);
    memValid = 1'b1; memRegWrite = 1'b1; memIsLoad = 1'b1;
    memDestReg = dest; memAluResult = addr; memLoadType = ty;
  endtask

  task automatic load_word(input string tag, input logic [4:0] dest, input logic [31:0] addr,
                           input logic [2:0] ty, input logic [31:0] rsp, input logic [31:0] exp);
    issue_load(dest, addr, ty);
    step();
    memValid = 1'b0;
    loadRspValid = 1'b1; loadRspData = rsp;
    step();
    loadRspValid = 1'b0;
    exp_retire++;
    check({tag, "_we"}, 64'(regWriteSignal), 64'd1);
    check({tag, "_data"}, 64'(writeData), 64'(exp));
  endtask

  initial begin
    rstN = 1'b0; memValid = 1'b0; memRegWrite = 1'b0; memIsLoad = 1'b0;
    memDestReg = '0; memAluResult = '0; memLoadType = LOAD_W;
    flush = 1'b0; loadRspValid = 1'b0; loadRspData = '0;

    #3;
    check("rst_we", 64'(regWriteSignal), 64'd0);
    check("rst_ready", 64'(memReady), 64'd0);
    check("rst_stall", 64'(wbStall), 64'd0);
    check("rst_retire", 64'(retireCount), 64'd0);
    check("rst_err", 64'(loadRspErr), 64'd0);
    #19 rstN = 1'b1;
    #1 check("ready_after_rst", 64'(memReady), 64'd1);

    // Back-to-back ALU writes
    step();
    issue_alu(5'd8, 32'd5);
    step(); exp_retire++;
    check("alu0_we", 64'(regWriteSignal), 64'd1);
    check("alu0_addr", 64'(writeRegNumber), 64'd8);
    check("alu0_data", 64'(writeData), 64'd5);
    issue_alu(5'd9, 32'd6);
    step(); exp_retire++;
    check("alu1_we", 64'(regWriteSignal), 64'd1);
    check("alu1_fwd", 64'({fwdValid, fwdRegNumber, fwdData}), {1'b1, 5'd9, 32'd6});
    issue_alu(5'd10, 32'd7);
    step(); exp_retire++;
    check("alu2_addr", 64'(writeRegNumber), 64'd10);
    check("alu2_data", 64'(writeData), 64'd7);
    check("alu_retire3", 64'(retireCount), 64'd3);
    memValid = 1'b0;
    step();
    check("pulse_end_we", 64'(regWriteSignal), 64'd0);
    check("pulse_end_hold", 64'({writeRegNumber, writeData}), {5'd10, 32'd7});

    // Write to $0 retires without writing
    issue_alu(5'd0, 32'h0000FFFF);
    step(); exp_retire++;
    memValid = 1'b0;
    check("zero_we", 64'(regWriteSignal), 64'd0);
    check("zero_retire", 64'(retireCount), 64'(exp_retire));

    // Load with response three cycles later
    issue_load(5'd4, 32'h0, LOAD_W);
    step();
    memValid = 1'b0;
    check("ld_stall1", 64'({wbStall, memReady}), 64'b10);
    step();
    check("ld_stall2", 64'({wbStall, memReady, regWriteSignal}), 64'b100);
    step();
    check("ld_stall3", 64'({wbStall, memReady}), 64'b10);
    loadRspValid = 1'b1; loadRspData = 32'h12345678;
    step(); exp_retire++;
    loadRspValid = 1'b0;
    check("ld_we", 64'(regWriteSignal), 64'd1);
    check("ld_addr", 64'(writeRegNumber), 64'd4);
    check("ld_data", 64'(writeData), 64'h12345678);
    check("ld_idle", 64'({wbStall, memReady}), 64'b01);
    check("ld_retire", 64'(retireCount), 64'(exp_retire));

    // Flush before response: drain and discard
    issue_load(5'd5, 32'h0, LOAD_W);
    step();
    memValid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("drain_stall", 64'(wbStall), 64'd1);
    loadRspValid = 1'b1; loadRspData = 32'h0000DEAD;
    step();
    loadRspValid = 1'b0;
    check("drain_we", 64'(regWriteSignal), 64'd0);
    check("drain_idle", 64'(memReady), 64'd1);
    check("drain_retire", 64'(retireCount), 64'(exp_retire));
    check("drain_err", 64'(loadRspErr), 64'd0);

    // Flush and response in the same cycle
    issue_load(5'd6, 32'h0, LOAD_W);
    step();
    memValid = 1'b0; flush = 1'b1; loadRspValid = 1'b1; loadRspData = 32'h0000BEEF;
    step();
    flush = 1'b0; loadRspValid = 1'b0;
    check("flushrsp_we", 64'(regWriteSignal), 64'd0);
    check("flushrsp_idle", 64'(memReady), 64'd1);
    check("flushrsp_retire", 64'(retireCount), 64'(exp_retire));
    step();
    check("flushrsp_err", 64'(loadRspErr), 64'd0);

`ifdef WB_SUBWORD_LOAD_EN
    load_word("lb3", 5'd7, 32'h3, LOAD_B, 32'h000000F0, 32'hFFFFFFF0);
    load_word("lbu3", 5'd7, 32'h3, LOAD_BU, 32'h000000F0, 32'h000000F0);
    load_word("lb0", 5'd7, 32'h0, LOAD_B, 32'h80000000, 32'hFFFFFF80);
    load_word("lh2", 5'd7, 32'h2, LOAD_H, 32'h12348001, 32'hFFFF8001);
    load_word("lhu0", 5'd7, 32'h0, LOAD_HU, 32'h80011234, 32'h00008001);
    load_word("lw1", 5'd7, 32'h1, LOAD_W, 32'hCAFEF00D, 32'hCAFEF00D);
`else
    load_word("lb_raw", 5'd7, 32'h3, LOAD_B, 32'h000000F0, 32'h000000F0);
    load_word("lh_raw", 5'd7, 32'h2, LOAD_H, 32'h12348001, 32'h12348001);
`endif
    check("sub_retire", 64'(retireCount), 64'(exp_retire));

    // Stray response in IDLE is sticky
    step();
    loadRspValid = 1'b1; loadRspData = 32'h11;
    step();
    loadRspValid = 1'b0;
    check("stray_err", 64'(loadRspErr), 64'd1);
    check("stray_we", 64'(regWriteSignal), 64'd0);
    step(); step();
    check("stray_err_held", 64'(loadRspErr), 64'd1);

    // Reset while waiting for a load
    issue_load(5'd3, 32'h0, LOAD_W);
    step();
    memValid = 1'b0;
    check("rstmid_stall", 64'(wbStall), 64'd1);
    rstN = 1'b0;
    #2;
    check("rstmid_out", 64'({regWriteSignal, memReady, wbStall, loadRspErr}), 64'b0);
    check("rstmid_retire", 64'(retireCount), 64'd0);
    #3 rstN = 1'b1;
    loadRspValid = 1'b1; loadRspData = 32'h55;
    step();
    loadRspValid = 1'b0;
    check("late_we", 64'(regWriteSignal), 64'd0);
    check("late_err", 64'(loadRspErr), 64'd1);
    check("late_retire", 64'(retireCount), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
